// File: rtl/rock_sequencer_if.sv
// Handshake bundle between the A/F rocking datapath (master) and rock_sequencer (slave).
// Inputs are level/strobe signals from the datapath; outputs are registered pulses and status.
interface rock_sequencer_if;
    logic       tick;
    logic       cry;
    logic       F0;
    logic       AF0;
    logic       fag_reset;
    logic       Flaag;
    logic       Alaag;
    logic       Fhoog;
    logic       motor_on;
    logic [2:0] state;
    logic       fault;

    // tick is a one-cycle strobe; cry/F0/AF0 are only meaningful on tick cycles.
    // Every output is a registered single-cycle pulse or a registered level.
    modport master (
        output tick, cry, F0, AF0,
        input  fag_reset, Flaag, Alaag, Fhoog, motor_on, state, fault
    );

    modport slave (
        input  tick, cry, F0, AF0,
        output fag_reset, Flaag, Alaag, Fhoog, motor_on, state, fault
    );
endinterface

// File: rtl/rock_sequencer.sv
// Cry-qualified rocking sequencer: reload, rock, then step F and A down to zero.
// Optional ramp watchdog (FAULT state, sticky fault flag) enabled by ROCK_WATCHDOG_EN.
module rock_sequencer #(
    parameter int QUIET_TICKS = 8,
    parameter int STEP_TICKS  = 4,
    parameter int CRY_FILTER  = 3
) (
    input  logic             clk,
    input  logic             reset,
    rock_sequencer_if.slave  bus
);
    localparam int QW = $clog2(QUIET_TICKS + 1);
    localparam int SW = $clog2(STEP_TICKS + 1);
    localparam int CW = $clog2(CRY_FILTER + 1);

    localparam logic [QW-1:0] QUIET_LAST = QW'(QUIET_TICKS - 1);
    localparam logic [SW-1:0] STEP_LAST  = SW'(STEP_TICKS - 1);
    localparam logic [CW-1:0] CRY_MAX    = CW'(CRY_FILTER);
    localparam logic [CW-1:0] CRY_THR    = CW'(CRY_FILTER - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RELOAD = 3'd1,
        S_ROCK   = 3'd2,
        S_RAMP_F = 3'd3,
        S_RAMP_A = 3'd4
`ifdef ROCK_WATCHDOG_EN
        , S_FAULT = 3'd5
`endif
    } state_t;

    state_t          r_state;
    logic            r_fag_reset;
    logic            r_flaag;
    logic            r_alaag;
    logic            r_motor_on;
    logic [CW-1:0]   r_cry_cnt;
    logic [QW-1:0]   r_quiet_cnt;
    logic [SW-1:0]   r_step_tmr;
`ifdef ROCK_WATCHDOG_EN
    logic            r_fault;
    logic [3:0]      r_step_cnt;
`endif

    logic w_cry_det;
    logic w_done;

    // Qualifies on the CRY_FILTER-th consecutive crying tick and on every one after it.
    assign w_cry_det = bus.tick & bus.cry & (r_cry_cnt >= CRY_THR);
    assign w_done    = (r_state == S_RAMP_F) ? bus.F0 : bus.AF0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_fag_reset <= 1'b0;
            r_flaag     <= 1'b0;
            r_alaag     <= 1'b0;
            r_motor_on  <= 1'b0;
            r_cry_cnt   <= '0;
            r_quiet_cnt <= '0;
            r_step_tmr  <= '0;
`ifdef ROCK_WATCHDOG_EN
            r_fault     <= 1'b0;
            r_step_cnt  <= '0;
`endif
        end else begin
            r_fag_reset <= 1'b0;
            r_flaag     <= 1'b0;
            r_alaag     <= 1'b0;

            if (bus.tick) begin
                if (!bus.cry)
                    r_cry_cnt <= '0;
                else if (r_cry_cnt != CRY_MAX)
                    r_cry_cnt <= r_cry_cnt + CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_motor_on <= 1'b0;
                    if (w_cry_det) begin
                        r_state     <= S_RELOAD;
                        r_fag_reset <= 1'b1;
                        r_motor_on  <= 1'b1;
                    end
                end
                S_RELOAD: begin
                    r_state     <= S_ROCK;
                    r_quiet_cnt <= '0;
                    r_motor_on  <= 1'b1;
                end
                S_ROCK: begin
                    r_motor_on <= 1'b1;
                    if (bus.tick) begin
                        if (bus.cry) begin
                            r_quiet_cnt <= '0;
                        end else if (r_quiet_cnt == QUIET_LAST) begin
                            r_state     <= S_RAMP_F;
                            r_quiet_cnt <= '0;
                            r_step_tmr  <= '0;
`ifdef ROCK_WATCHDOG_EN
                            r_step_cnt  <= '0;
`endif
                        end else begin
                            r_quiet_cnt <= r_quiet_cnt + QW'(1);
                        end
                    end
                end
                S_RAMP_F, S_RAMP_A: begin
                    r_motor_on <= 1'b1;
                    if (bus.tick) begin
                        if (w_cry_det) begin
                            r_state     <= S_RELOAD;
                            r_fag_reset <= 1'b1;
                            r_step_tmr  <= '0;
                        end else if (w_done) begin
                            r_step_tmr <= '0;
`ifdef ROCK_WATCHDOG_EN
                            r_step_cnt <= '0;
`endif
                            if (r_state == S_RAMP_F) begin
                                r_state <= S_RAMP_A;
                            end else begin
                                r_state    <= S_IDLE;
                                r_motor_on <= 1'b0;
                            end
                        end else if (r_step_tmr == STEP_LAST) begin
                            r_step_tmr <= '0;
`ifdef ROCK_WATCHDOG_EN
                            // Seven pulses without reaching zero means the datapath is stuck.
                            if (r_step_cnt == 4'd7) begin
                                r_state    <= S_FAULT;
                                r_motor_on <= 1'b0;
                                r_fault    <= 1'b1;
                            end else begin
                                r_step_cnt <= r_step_cnt + 4'd1;
                                if (r_state == S_RAMP_F) r_flaag <= 1'b1;
                                else                     r_alaag <= 1'b1;
                            end
`else
                            if (r_state == S_RAMP_F) r_flaag <= 1'b1;
                            else                     r_alaag <= 1'b1;
`endif
                        end else begin
                            r_step_tmr <= r_step_tmr + SW'(1);
                        end
                    end
                end
`ifdef ROCK_WATCHDOG_EN
                S_FAULT: begin
                    r_motor_on <= 1'b0;
                    r_fault    <= 1'b1;
                end
`endif
                default: begin
                    r_state    <= S_IDLE;
                    r_motor_on <= 1'b0;
                end
            endcase
        end
    end

    assign bus.fag_reset = r_fag_reset;
    assign bus.Flaag     = r_flaag;
    assign bus.Alaag     = r_alaag;
    assign bus.Fhoog     = 1'b0;
    assign bus.motor_on  = r_motor_on;
    assign bus.state     = r_state;
`ifdef ROCK_WATCHDOG_EN
    assign bus.fault     = r_fault;
`else
    assign bus.fault     = 1'b0;
`endif
endmodule

// File: tb/tb_rock_sequencer.sv
// Directed bench for rock_sequencer with an A/F datapath model and a pulse scoreboard.
// Watchdog checks follow ROCK_WATCHDOG_EN the same way the design does.
module tb_rock_sequencer;
    logic clk;
    logic reset;

    rock_sequencer_if u_if ();

    rock_sequencer #(
        .QUIET_TICKS (8),
        .STEP_TICKS  (4),
        .CRY_FILTER  (3)
    ) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (u_if.slave)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // datapath model: A/F counters driven by the sequencer pulses
    int   dp_a;
    int   dp_f;
    logic f0_hold_low;

    initial begin
        dp_a = 0;
        dp_f = 0;
    end

    always @(posedge clk) begin
        if (u_if.fag_reset === 1'b1) begin
            dp_a <= 5;
            dp_f <= 5;
        end else if (u_if.Flaag === 1'b1) begin
            dp_f <= dp_f - 1;
        end else if (u_if.Alaag === 1'b1) begin
            dp_a <= dp_a - 1;
        end
    end

    assign u_if.F0  = f0_hold_low ? 1'b0 : (dp_f <= 0);
    assign u_if.AF0 = (dp_f <= 0) && (dp_a <= 0);

    // scoreboard: pulse codes {fag_reset, Flaag, Alaag}
    logic [2:0] exp_q[$];
    int chk_cnt;
    int pass_cnt;
    int fail_cnt;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        logic [2:0] w_obs;
        w_obs = {u_if.fag_reset, u_if.Flaag, u_if.Alaag};
        if (w_obs !== 3'b000) begin
            if (exp_q.size() == 0) check("unexpected_pulse", {5'd0, w_obs}, 8'd0);
            else                   check("pulse", {5'd0, w_obs}, {5'd0, exp_q.pop_front()});
        end
    end

    // driver tasks; each starts and ends 1 time unit after a rising edge
    task automatic do_tick(input logic c);
        u_if.tick = 1'b1;
        u_if.cry  = c;
        @(posedge clk); #1;
        u_if.tick = 1'b0;
        u_if.cry  = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
    endtask

    task automatic qualify_cry();
        do_tick(1'b1);
        do_tick(1'b1);
        exp_q.push_back(3'b100);
        u_if.tick = 1'b1;
        u_if.cry  = 1'b1;
        @(posedge clk); #1;
        u_if.tick = 1'b0;
        u_if.cry  = 1'b0;
        check("reload_state", {5'd0, u_if.state}, 8'd1);
        check("reload_motor", {7'd0, u_if.motor_on}, 8'd1);
        check("reload_fag",   {7'd0, u_if.fag_reset}, 8'd1);
        @(posedge clk); #1;
        check("rock_state", {5'd0, u_if.state}, 8'd2);
        check("rock_motor", {7'd0, u_if.motor_on}, 8'd1);
        check("rock_fag",   {7'd0, u_if.fag_reset}, 8'd0);
    endtask

    task automatic go_ramp_f();
        repeat (7) do_tick(1'b0);
        check("quiet_7_rock", {5'd0, u_if.state}, 8'd2);
        do_tick(1'b0);
        check("quiet_8_ramp_f", {5'd0, u_if.state}, 8'd3);
    endtask

    logic alt_cry;

    task automatic ramp_pulses(input int n, input logic [2:0] code, input logic alt);
        for (int p = 0; p < n; p++) begin
            for (int t = 0; t < 4; t++) begin
                if (t == 3) exp_q.push_back(code);
                do_tick(alt ? alt_cry : 1'b0);
                if (alt) alt_cry = ~alt_cry;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        chk_cnt     = 0;
        pass_cnt    = 0;
        fail_cnt    = 0;
        f0_hold_low = 1'b0;
        alt_cry     = 1'b1;
        u_if.tick   = 1'b0;
        u_if.cry    = 1'b0;
        reset       = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // reset state
        check("rst_state", {5'd0, u_if.state}, 8'd0);
        check("rst_motor", {7'd0, u_if.motor_on}, 8'd0);
        check("rst_pulses", {5'd0, u_if.fag_reset, u_if.Flaag, u_if.Alaag}, 8'd0);
        check("rst_fault", {7'd0, u_if.fault}, 8'd0);
        check("rst_fhoog", {7'd0, u_if.Fhoog}, 8'd0);

        // two crying ticks are not enough
        do_tick(1'b1);
        do_tick(1'b1);
        check("two_cries_idle", {5'd0, u_if.state}, 8'd0);
        do_tick(1'b0);
        check("calm_idle", {5'd0, u_if.state}, 8'd0);

        // full ramp-down: 5 Flaag, then 5 Alaag, then idle
        qualify_cry();
        go_ramp_f();
        ramp_pulses(5, 3'b010, 1'b0);
        check("ramp_f_before_f0", {5'd0, u_if.state}, 8'd3);
        do_tick(1'b0);
        check("enter_ramp_a", {5'd0, u_if.state}, 8'd4);
        ramp_pulses(5, 3'b001, 1'b0);
        check("ramp_a_before_af0", {5'd0, u_if.state}, 8'd4);
        do_tick(1'b0);
        check("done_idle", {5'd0, u_if.state}, 8'd0);
        check("done_motor", {7'd0, u_if.motor_on}, 8'd0);

        // cry during RAMP_A after two Alaag pulses
        qualify_cry();
        go_ramp_f();
        ramp_pulses(5, 3'b010, 1'b0);
        do_tick(1'b0);
        check("enter_ramp_a_2", {5'd0, u_if.state}, 8'd4);
        ramp_pulses(2, 3'b001, 1'b0);
        qualify_cry();

        // ramp-down with alternating cry never requalifies
        go_ramp_f();
        alt_cry = 1'b1;
        ramp_pulses(5, 3'b010, 1'b1);
        do_tick(alt_cry);
        alt_cry = ~alt_cry;
        check("alt_ramp_a", {5'd0, u_if.state}, 8'd4);
        ramp_pulses(5, 3'b001, 1'b1);
        do_tick(alt_cry);
        check("alt_idle", {5'd0, u_if.state}, 8'd0);
        check("alt_motor", {7'd0, u_if.motor_on}, 8'd0);

        // F0 stuck low
        qualify_cry();
        go_ramp_f();
        f0_hold_low = 1'b1;
`ifdef ROCK_WATCHDOG_EN
        ramp_pulses(7, 3'b010, 1'b0);
        check("wd_before_fault", {5'd0, u_if.state}, 8'd3);
        repeat (4) do_tick(1'b0);
        check("wd_fault_state", {5'd0, u_if.state}, 8'd5);
        check("wd_fault_flag", {7'd0, u_if.fault}, 8'd1);
        check("wd_fault_motor", {7'd0, u_if.motor_on}, 8'd0);
        repeat (4) do_tick(1'b1);
        check("wd_fault_sticky", {5'd0, u_if.state}, 8'd5);
        check("wd_fault_sticky_flag", {7'd0, u_if.fault}, 8'd1);
`else
        ramp_pulses(9, 3'b010, 1'b0);
        check("nowd_still_ramp_f", {5'd0, u_if.state}, 8'd3);
        check("nowd_fault_low", {7'd0, u_if.fault}, 8'd0);
        check("nowd_motor", {7'd0, u_if.motor_on}, 8'd1);
`endif
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        f0_hold_low = 1'b0;
        check("post_rst_state", {5'd0, u_if.state}, 8'd0);
        check("post_rst_fault", {7'd0, u_if.fault}, 8'd0);
        check("post_rst_motor", {7'd0, u_if.motor_on}, 8'd0);

        // reset on the tick that would produce a Flaag
        qualify_cry();
        go_ramp_f();
        repeat (3) do_tick(1'b0);
        u_if.tick = 1'b1;
        u_if.cry  = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        u_if.tick = 1'b0;
        reset     = 1'b0;
        check("rst_drop_flaag", {7'd0, u_if.Flaag}, 8'd0);
        check("rst_drop_state", {5'd0, u_if.state}, 8'd0);
        check("rst_drop_motor", {7'd0, u_if.motor_on}, 8'd0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_drop_quiet", {5'd0, u_if.fag_reset, u_if.Flaag, u_if.Alaag}, 8'd0);

        check("queue_empty", 8'(exp_q.size()), 8'd0);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
